// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the row-multiplexed RGB LED matrix driver.
// Holds the scan state encoding, colour slot indices and the gamma duty mapping.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } scan_state_e;

    localparam int unsigned COL_R = 2;
    localparam int unsigned COL_G = 1;
    localparam int unsigned COL_B = 0;

    // Full scale is pinned to full scale so the brightest code stays brightest.
    function automatic int unsigned gamma_duty(input int unsigned v, input int unsigned bits);
        int unsigned vmax;
        vmax = (32'd1 << bits) - 32'd1;
        if (v == vmax) begin
            return vmax;
        end
        return (v * v) >> bits;
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-banked pixel store: one write port into either bank and a registered
// read port that returns a whole row of one bank per read.
module led_frame_buffer #(
    parameter int unsigned p_row_num    = 8,
    parameter int unsigned p_column_num = 8,
    parameter int unsigned p_word_bits  = 12
) (
    input  logic                                  clk,
    input  logic                                  wr_en_i,
    input  logic                                  wr_bank_i,
    input  logic [$clog2(p_row_num)-1:0]          wr_row_i,
    input  logic [$clog2(p_column_num)-1:0]       wr_col_i,
    input  logic [p_word_bits-1:0]                wr_data_i,
    input  logic                                  rd_en_i,
    input  logic                                  rd_bank_i,
    input  logic [$clog2(p_row_num)-1:0]          rd_row_i,
    output logic [p_column_num*p_word_bits-1:0]   rd_data_o
);

    logic [p_word_bits-1:0] mem_q [2][p_row_num][p_column_num];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    for (genvar c = 0; c < p_column_num; c++) begin : g_rd_col
        always_ff @(posedge clk) begin
            if (rd_en_i) begin
                rd_data_o[c*p_word_bits +: p_word_bits] <= mem_q[rd_bank_i][rd_row_i][c];
            end
        end
    end

endmodule

// File: rtl/led_matrix_pwm_scanner.sv
// Row-scanning RGB LED matrix driver with per-colour PWM and a bank-swapped frame store.
// Define LED_MATRIX_GAMMA_EN to map intensities through a square-law duty curve.
module led_matrix_pwm_scanner
    import led_matrix_pkg::*;
#(
    parameter int unsigned p_row_num      = 8,
    parameter int unsigned p_column_num   = 8,
    parameter int unsigned p_pwm_bits     = 4,
    parameter int unsigned p_slot_cycles  = 2,
    parameter int unsigned p_blank_cycles = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [$clog2(p_row_num)-1:0]      wr_row,
    input  logic [$clog2(p_column_num)-1:0]   wr_col,
    input  logic [3*p_pwm_bits-1:0]           wr_rgb,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic [p_row_num-1:0]              row_anode,
    output logic [3*p_column_num-1:0]         col_cell,
    output logic                              frame_done
);

    localparam int unsigned ROW_W  = $clog2(p_row_num);
    localparam int unsigned WORD_W = 3 * p_pwm_bits;
    localparam int unsigned SUB_W  = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
    localparam int unsigned BLK_W  = (p_blank_cycles > 1) ? $clog2(p_blank_cycles) : 1;
    localparam logic [p_row_num-1:0] ROW0 = {{(p_row_num-1){1'b0}}, 1'b1};

    scan_state_e                 state_q, state_d;
    logic [ROW_W-1:0]            row_q, row_d;
    logic [BLK_W-1:0]            blank_q, blank_d;
    logic [SUB_W-1:0]            sub_q, sub_d;
    logic [p_pwm_bits-1:0]       slot_q, slot_d;
    logic                        front_q, front_d;
    logic                        pending_q, pending_d;
    logic                        swap_ack_q, swap_ack_d;
    logic                        frame_done_q, frame_done_d;
    logic                        apply_swap;
    logic                        show;
    logic                        fb_wr_en;
    logic [p_column_num*WORD_W-1:0] row_data;

    function automatic logic [p_pwm_bits-1:0] pixel_duty(input logic [p_pwm_bits-1:0] v);
`ifdef LED_MATRIX_GAMMA_EN
        return p_pwm_bits'(gamma_duty(32'(v), p_pwm_bits));
`else
        return v;
`endif
    endfunction

    assign fb_wr_en = wr_valid & ~pending_q
                    & (32'(wr_row) < p_row_num) & (32'(wr_col) < p_column_num);

    led_frame_buffer #(
        .p_row_num    (p_row_num),
        .p_column_num (p_column_num),
        .p_word_bits  (WORD_W)
    ) u_frame_buffer (
        .clk       (clk),
        .wr_en_i   (fb_wr_en),
        .wr_bank_i (~front_q),
        .wr_row_i  (wr_row),
        .wr_col_i  (wr_col),
        .wr_data_i (wr_rgb),
        .rd_en_i   (state_q == S_BLANK),
        .rd_bank_i (front_q),
        .rd_row_i  (row_q),
        .rd_data_o (row_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            blank_q      <= '0;
            sub_q        <= '0;
            slot_q       <= '0;
            front_q      <= 1'b0;
            pending_q    <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            blank_q      <= blank_d;
            sub_q        <= sub_d;
            slot_q       <= slot_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            swap_ack_q   <= swap_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        blank_d      = blank_q;
        sub_d        = sub_q;
        slot_d       = slot_q;
        front_d      = front_q;
        pending_d    = pending_q;
        swap_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        apply_swap   = 1'b0;

        case (state_q)
            S_IDLE: begin
                apply_swap = pending_q;
                if (enable) begin
                    state_d = S_BLANK;
                    blank_d = '0;
                end
            end
            S_BLANK: begin
                if (blank_q == BLK_W'(p_blank_cycles - 1)) begin
                    state_d = S_SHOW;
                    sub_d   = '0;
                    slot_d  = '0;
                end else begin
                    blank_d = blank_q + BLK_W'(1);
                end
            end
            S_SHOW: begin
                if (sub_q == SUB_W'(p_slot_cycles - 1)) begin
                    sub_d = '0;
                    if (slot_q == '1) begin
                        // A disabled mid-frame row parks on itself so re-enable repeats it.
                        if (row_q == ROW_W'(p_row_num - 1)) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            apply_swap   = pending_q;
                        end else if (enable) begin
                            row_d = row_q + ROW_W'(1);
                        end
                        state_d = enable ? S_BLANK : S_IDLE;
                        blank_d = '0;
                    end else begin
                        slot_d = slot_q + p_pwm_bits'(1);
                    end
                end else begin
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (apply_swap) begin
            front_d    = ~front_q;
            pending_d  = 1'b0;
            swap_ack_d = 1'b1;
        end else if (swap_req) begin
            pending_d = 1'b1;
        end
    end

    assign show       = (state_q == S_SHOW);
    assign wr_ready   = ~pending_q;
    assign swap_ack   = swap_ack_q;
    assign frame_done = frame_done_q;
    assign row_anode  = show ? (ROW0 << row_q) : '0;

    for (genvar c = 0; c < p_column_num; c++) begin : g_col
        assign col_cell[3*c+COL_R] = show & (slot_q < pixel_duty(row_data[c*WORD_W + COL_R*p_pwm_bits +: p_pwm_bits]));
        assign col_cell[3*c+COL_G] = show & (slot_q < pixel_duty(row_data[c*WORD_W + COL_G*p_pwm_bits +: p_pwm_bits]));
        assign col_cell[3*c+COL_B] = show & (slot_q < pixel_duty(row_data[c*WORD_W + COL_B*p_pwm_bits +: p_pwm_bits]));
    end

endmodule
